// File: rtl/mem_loader.sv
// Program loader: receives a length/payload/checksum byte stream and writes the payload to memory from address 0.
// It keeps the CPU held until a load has completed with a passing checksum.
module mem_loader #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ld_write,
  output logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [AW-1:0] last, last_nxt;
  logic [DW-1:0] sum, sum_nxt;
  logic          ld_write_nxt;
  logic [AW-1:0] ld_addr_nxt;
  logic [DW-1:0] ld_data_nxt;
  logic          in_ready_nxt, busy_nxt, cpu_hold_nxt, done_nxt, err_nxt;
  logic          xfer;
  logic          len_ok;

  assign xfer   = in_valid && in_ready;
  assign len_ok = (in_data != '0) && (32'(in_data) <= DEPTH);

  // State, counters and all outputs share one register stage
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      last     <= '0;
      sum      <= '0;
      ld_write <= 1'b0;
      ld_addr  <= '0;
      ld_data  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      last     <= last_nxt;
      sum      <= sum_nxt;
      ld_write <= ld_write_nxt;
      ld_addr  <= ld_addr_nxt;
      ld_data  <= ld_data_nxt;
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
      cpu_hold <= cpu_hold_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  // Next state, datapath updates and output decode of the next state
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    last_nxt     = last;
    sum_nxt      = sum;
    ld_write_nxt = 1'b0;
    ld_addr_nxt  = ld_addr;
    ld_data_nxt  = ld_data;

    unique case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          if (len_ok) begin
            // Keep N-1 so that N = 2^AW still fits in AW bits
            last_nxt  = AW'(in_data - DW'(1));
            sum_nxt   = '0;
            addr_nxt  = '0;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_ERROR;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          ld_write_nxt = 1'b1;
          ld_addr_nxt  = addr;
          ld_data_nxt  = in_data;
          sum_nxt      = DW'(sum + in_data);
          addr_nxt     = AW'(addr + AW'(1));
          if (addr == last) state_nxt = S_SUM;
        end
      end
      S_SUM: begin
        if (xfer) state_nxt = (DW'(sum + in_data) == '0) ? S_RUN : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase

    in_ready_nxt = (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_SUM);
    busy_nxt     = in_ready_nxt;
    cpu_hold_nxt = (state_nxt != S_RUN);
    done_nxt     = (state_nxt == S_RUN);
    err_nxt      = (state_nxt == S_ERROR);
  end

endmodule
